// File: rtl/mem_lsu.sv
// Load/store unit: turns byte/half/word core requests into single aligned 32-bit
// bus accesses with lane masks, store replication and load alignment/extension.
module mem_lsu #(
    parameter int STALL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [4:0]  rd_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        en_o,
    output logic        we_o,
    output logic [31:0] data_o,
    output logic [29:0] addr_o,
    output logic [3:0]  byte_mask_o,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        err_i
);
    localparam int CW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RESP, S_DONE, S_ERR, S_FAULT} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic           we_q, uns_q;
    logic [1:0]     size_q, off_q;
    logic [4:0]     tag_q, rd_out_q;
    logic [29:0]    waddr_q;
    logic [3:0]     mask_q, mask_cap;
    logic [31:0]    sdata_q, sdata_cap;
    logic [31:0]    rdata_q, ld_shift, ld_ext;
    logic           misalign_cap, capture, resp_ok;

    assign misalign_cap = (size_i == 2'b11) ||
                          (size_i == 2'b01 && addr_i[0]) ||
                          (size_i == 2'b10 && addr_i[1:0] != 2'b00);

    always_comb begin
        mask_cap = 4'b1111;
        case (size_i)
            2'b00:   mask_cap = 4'b0001 << addr_i[1:0];
            2'b01:   mask_cap = 4'b0011 << addr_i[1:0];
            default: mask_cap = 4'b1111;
        endcase
    end

    // Each lane picks the source byte it would hold after replicating the
    // right-justified store operand across the word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        always_comb begin
            case (size_i)
                2'b00:   sdata_cap[8*gi +: 8] = wdata_i[7:0];
                2'b01:   sdata_cap[8*gi +: 8] = wdata_i[8*(gi%2) +: 8];
                default: sdata_cap[8*gi +: 8] = wdata_i[8*gi +: 8];
            endcase
        end
    end

    assign ld_shift = data_i >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_ext = {{16{~uns_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    assign capture = (state_q == S_IDLE) && req_i;
    assign resp_ok = !err_i && (we_q || valid_i);
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE:  if (req_i) state_d = misalign_cap ? S_FAULT : S_ISSUE;
            S_ISSUE: begin
                if (err_i) begin
                    state_d = S_ERR;
                end else if (!stall_i) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    // A zero limit disables the timeout; the counter just wraps.
                    if (STALL_LIMIT != 0 && cnt_inc == CW'(STALL_LIMIT))
                        state_d = S_ERR;
                end
            end
            S_RESP:  state_d = resp_ok ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'b00;
            off_q    <= 2'b00;
            tag_q    <= '0;
            waddr_q  <= '0;
            mask_q   <= '0;
            sdata_q  <= '0;
            rdata_q  <= '0;
            rd_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= we_i;
                uns_q   <= unsigned_i;
                size_q  <= size_i;
                off_q   <= addr_i[1:0];
                tag_q   <= rd_i;
                waddr_q <= addr_i[31:2];
                mask_q  <= mask_cap;
                sdata_q <= sdata_cap;
            end
            if (state_q == S_RESP && resp_ok) begin
                rd_out_q <= tag_q;
                if (!we_q) rdata_q <= ld_ext;
            end
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign misalign_o  = (state_q == S_FAULT);
    assign bus_err_o   = (state_q == S_ERR);
    assign en_o        = (state_q == S_ISSUE);
    assign we_o        = we_q;
    assign addr_o      = waddr_q;
    assign byte_mask_o = mask_q;
    assign data_o      = sdata_q;
    assign rdata_o     = rdata_q;
    assign rd_o        = rd_out_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed and randomized checks of mem_lsu against an arithmetic reference model;
// the bench plays the bus master, driving and sampling on the falling edge.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, we_i, unsigned_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  rd_i;
    logic        busy_o, done_o, misalign_o, bus_err_o, en_o, we_o;
    logic [31:0] rdata_o, data_o;
    logic [4:0]  rd_o;
    logic [29:0] addr_o;
    logic [3:0]  byte_mask_o;
    logic [31:0] data_i;
    logic        valid_i, stall_i, err_i;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_rdata = 32'h0;
    logic [4:0]  model_rd    = 5'h0;

    always #5 clk = ~clk;

    mem_lsu #(.STALL_LIMIT(16)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .rd_o(rd_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .en_o(en_o), .we_o(we_o),
        .data_o(data_o), .addr_o(addr_o), .byte_mask_o(byte_mask_o),
        .data_i(data_i), .valid_i(valid_i), .stall_i(stall_i), .err_i(err_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: pick the addressed bytes, then extend with plain arithmetic.
    function automatic logic [31:0] exp_load(logic [31:0] d, logic [1:0] sz, logic u, logic [1:0] off);
        longint v, n;
        v = longint'(d) >> (8 * off);
        n = 8 << sz;
        v = v % (longint'(1) << n);
        if (!u && v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_mask(logic [1:0] sz, logic [1:0] off);
        int n = 1 << sz;
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_sdata(logic [1:0] sz, logic [31:0] d);
        logic [31:0] r;
        int n = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(d >> (8 * (i % n)));
        return r;
    endfunction

    task automatic drive_req(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tag);
        req_i = 1'b1; we_i = w; size_i = sz; unsigned_i = u;
        addr_i = a; wdata_i = wd; rd_i = tag;
    endtask

    // One aligned access: nstall stalled issue cycles, then RESP with bus data or error.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tag,
                             input int nstall, input logic [31:0] bus, input logic berr);
        logic [3:0]  em;
        logic [31:0] ed;
        em = exp_mask(sz, a[1:0]);
        ed = exp_sdata(sz, wd);
        @(negedge clk);
        check("idle_busy", {31'b0, busy_o}, 32'h0);
        drive_req(w, sz, u, a, wd, tag);
        for (int i = 0; i <= nstall; i++) begin
            @(negedge clk);
            req_i = 1'b0;
            wdata_i = ~wd;
            check("issue_en", {31'b0, en_o}, 32'h1);
            check("issue_we", {31'b0, we_o}, {31'b0, w});
            check("issue_addr", {2'b0, addr_o}, {2'b0, a[31:2]});
            check("issue_mask", {28'b0, byte_mask_o}, {28'b0, em});
            if (w) check("issue_data", data_o, ed);
            stall_i = (i < nstall);
        end
        @(negedge clk);
        check("resp_en", {31'b0, en_o}, 32'h0);
        valid_i = !w && !berr;
        data_i  = bus;
        err_i   = berr;
        @(negedge clk);
        valid_i = 1'b0; err_i = 1'b0; data_i = $urandom();
        if (!berr) begin
            if (!w) model_rdata = exp_load(bus, sz, u, a[1:0]);
            model_rd = tag;
        end
        check("done_pulse", {31'b0, done_o}, {31'b0, !berr});
        check("err_pulse", {31'b0, bus_err_o}, {31'b0, berr});
        check("rdata", rdata_o, model_rdata);
        check("rd_tag", {27'b0, rd_o}, {27'b0, model_rd});
        @(negedge clk);
        check("after_idle", {29'b0, busy_o, done_o, bus_err_o}, 32'h0);
    endtask

    task automatic do_misalign(input logic w, input logic [1:0] sz, input logic [31:0] a);
        @(negedge clk);
        drive_req(w, sz, 1'b0, a, 32'h1234_5678, 5'd9);
        @(negedge clk);
        req_i = 1'b0;
        check("mis_pulse", {30'b0, misalign_o, en_o}, 32'h2);
        @(negedge clk);
        check("mis_after", {29'b0, misalign_o, en_o, busy_o}, 32'h0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
        addr_i = '0; wdata_i = '0; rd_i = '0;
        data_i = '0; valid_i = 1'b0; stall_i = 1'b0; err_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", {26'b0, busy_o, done_o, misalign_o, bus_err_o, en_o, we_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_rd", {27'b0, rd_o}, 32'h0);
        check("rst_mask", {28'b0, byte_mask_o}, 32'h0);
        rst = 1'b0;

        do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd7, 0, 32'hDEADBEEF, 1'b0);
        check("lw_const", rdata_o, 32'hDEADBEEF);
        do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd3, 0, 32'h80FF1234, 1'b0);
        check("lb_const", rdata_o, 32'hFFFFFF80);
        do_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd4, 0, 32'h80FF1234, 1'b0);
        check("lbu_const", rdata_o, 32'h00000080);
        do_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd5, 0, 32'h80FF1234, 1'b0);
        check("lh_const", rdata_o, 32'hFFFF80FF);
        do_access(1'b1, 2'b01, 1'b0, 32'h206, 32'h0000ABCD, 5'd6, 3, 32'h0, 1'b0);

        do_misalign(1'b0, 2'b10, 32'h101);
        do_misalign(1'b1, 2'b01, 32'h3);
        do_misalign(1'b0, 2'b11, 32'h40);

        do_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd11, 0, 32'h11112222, 1'b1);
        do_access(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 5'd12, 0, 32'h33334444, 1'b0);

        // Permanent stall: 16 stalled issue cycles, then a timeout error.
        @(negedge clk);
        drive_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd13);
        stall_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req_i = 1'b0;
            check("to_en", {31'b0, en_o}, 32'h1);
        end
        @(negedge clk);
        check("to_err", {30'b0, bus_err_o, en_o}, 32'h2);
        stall_i = 1'b0;
        @(negedge clk);
        check("to_after", {29'b0, bus_err_o, en_o, busy_o}, 32'h0);
        do_access(1'b0, 2'b10, 1'b0, 32'h408, 32'h0, 5'd14, 0, 32'hCAFEF00D, 1'b0);

        // Reset in the middle of a stalled issue.
        @(negedge clk);
        drive_req(1'b1, 2'b10, 1'b0, 32'h500, 32'h55AA55AA, 5'd15);
        stall_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            req_i = 1'b0;
        end
        check("pre_rst_en", {31'b0, en_o}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; stall_i = 1'b0;
        check("rst_mid", {30'b0, busy_o, en_o}, 32'h0);
        model_rdata = 32'h0; model_rd = 5'h0;
        repeat (4) begin
            @(negedge clk);
            check("rst_quiet", {29'b0, done_o, bus_err_o, en_o}, 32'h0);
        end

        for (int t = 0; t < 40; t++) begin
            sz = 2'($urandom_range(0, 2));
            a  = ($urandom() & 32'hFFFF_FFFC) | (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 1));
            do_access(1'($urandom()), sz, 1'($urandom()), a, $urandom(), 5'($urandom()),
                      $urandom_range(0, 3), $urandom(), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Core-side load/store unit, directly upstream of the pipelined-bus master adapter.
- Takes byte/half/word load and store requests with byte addresses and issues one aligned 32-bit word access at a time. It generates byte lanes, replicates store data, and aligns and sign- or zero-extends load data.
- Holds each request on the bus through stalls, detects misalignment, and reports bus errors and stall timeouts.
- Single outstanding access.

Parameters:
- STALL_LIMIT, 16: maximum consecutive stalled issue cycles before the access is aborted as a bus error. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  1  core request; sampled only when busy_o=0
- we_i  in  1  1=store, 0=load
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-justified
- rd_i  in  5  load destination tag
- busy_o  out  1  unit occupied; core holds off new requests
- done_o  out  1  one-cycle pulse on successful completion
- rdata_o  out  32  aligned, extended load data; valid with done_o on loads
- rd_o  out  5  tag returned with done_o
- misalign_o  out  1  one-cycle pulse: misaligned or illegal-size request; no bus access made
- bus_err_o  out  1  one-cycle pulse: bus error or stall timeout
- en_o  out  1  to master en_i
- we_o  out  1  to master we_i
- data_o  out  32  to master data_i
- addr_o  out  30  to master addr_i (word address)
- byte_mask_o  out  4  to master byte_mask_i
- data_i  in  32  from master data_o
- valid_i  in  1  from master valid_o
- stall_i  in  1  from master stall_o
- err_i  in  1  from master err_o

Behaviour:

Reset:
- State IDLE; counter 0.
- All outputs 0, including done_o, misalign_o, bus_err_o, busy_o, en_o, rdata_o and rd_o.
- If rst arrives mid-access, en_o is low from the next cycle and no completion is reported.

Capture (IDLE, req_i=1):
- Register we, size, unsigned, addr[1:0], rd, word address addr_i[31:2], byte mask and replicated store data.
- Misaligned means size=11, half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned goes to FAULT.
  - Otherwise go to ISSUE.
- req_i is ignored while busy_o=1.

Byte mask:
- Byte: 0001<<addr[1:0].
- Half: 0011<<addr[1:0].
- Word: 1111.

Store data:
- Byte: wdata[7:0] replicated x4.
- Half: wdata[15:0] replicated x2.
- Word: wdata unchanged.

busy_o = (state != IDLE).

States:
- FAULT: misalign_o=1 for one cycle, then IDLE.
- ISSUE:
  - en_o=1; we_o, addr_o, byte_mask_o and data_o come from the registers and are held constant while stall_i=1.
  - stall_i=0 means the access is accepted; go to RESP.
  - stall_i=1 increments the counter. When STALL_LIMIT!=0 and the counter reaches STALL_LIMIT, go to ERR; en_o drops next cycle.
  - err_i=1 in ISSUE goes to ERR.
  - The counter clears on leaving ISSUE.
- RESP (cycle after acceptance; en_o=0):
  - Load with valid_i=1: rdata_o is data_i>>(8*addr[1:0]), truncated to size, then extended per unsigned; rd_o=tag. Go to DONE.
  - Store with err_i=0: go to DONE.
  - err_i=1, or a load with valid_i=0: go to ERR.
- DONE: done_o=1 for one cycle; rdata_o and rd_o hold until the next done_o. Then IDLE.
- ERR: bus_err_o=1 for one cycle, then IDLE. rdata_o is unchanged.

Timing:
- Minimum latency is req at cycle N, en_o at N+1, RESP at N+2, done_o at N+3.
- A new request can be accepted in the cycle after done_o, misalign_o or bus_err_o.
- Status pulses are mutually exclusive.

Test Plan:
- LW addr 0x100, no stall, data_i=0xDEADBEEF → en_o at cycle 1 with addr_o=0x40, mask 1111, we_o=0; done_o at cycle 3, rdata_o=0xDEADBEEF, rd_o echoed.
- LB signed addr 0x103, data_i=0x80FF1234 → mask 1000, rdata_o=0xFFFFFF80. Same with LBU → 0x00000080. LH addr 0x102 signed → 0xFFFF80FF.
- SH addr 0x206, wdata 0x0000ABCD, stall_i high 3 cycles → en_o held 4 cycles with addr_o=0x81, mask 1100 and data_o=0xABCDABCD stable throughout; done_o 2 cycles after stall drops.
- LW addr 0x101, then SH addr 0x3, then size=11 → misalign_o pulse each time at cycle 1; en_o never asserted.
- Error cases, each followed by a clean LW:
  - err_i in RESP → bus_err_o pulse and done_o=0.
  - stall_i held permanently with STALL_LIMIT=16 → bus_err_o after 16 stalled cycles, then en_o=0.
  - The following LW completes normally.
- rst asserted while in ISSUE under stall → next cycle busy_o=0, en_o=0, and no done_o or bus_err_o pulse appears.
